// File: rtl/fast_field_sequencer_if.sv
// Byte-in / decoded-field-out stream bundle for fast_field_sequencer.
// The slave side is the sequencer; the master side feeds bytes and sinks fields.
interface fast_field_sequencer_if #(
  parameter int OUT_WIDTH = 64,
  parameter int FW        = 5
);
  logic                 in_valid;
  logic [7:0]           in_byte;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_value;
  logic                 out_is_null;
  logic [FW-2:0]        out_field_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_value,
    input  out_is_null, out_field_idx, out_last
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_value,
    output out_is_null, out_field_idx, out_last
  );
endinterface

// File: rtl/fast_field_sequencer.sv
// Splits a FAST byte stream into stop-bit fields, runs each through one
// shared uint decoder and streams the decoded values out in field order.
module fast_field_sequencer #(
  parameter int MAX_BYTES  = 10,
  parameter int OUT_WIDTH  = 64,
  parameter int MAX_FIELDS = 16,
  parameter int CW         = $clog2(MAX_BYTES) + 1,
  parameter int FW         = $clog2(MAX_FIELDS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fast_field_sequencer_if.slave  bus,
  input  logic [MAX_FIELDS-1:0]  tmpl_nullable,
  input  logic [FW-1:0]          tmpl_num_fields,
  output logic [MAX_BYTES*8-1:0] dec_msg_bytes,
  output logic [CW-1:0]          dec_byte_count,
  output logic                   dec_nullable,
  output logic                   dec_valid_in,
  input  logic                   dec_valid_out,
  input  logic [OUT_WIDTH-1:0]   dec_value,
  input  logic                   dec_is_null,
  output logic                   err,
  output logic [7:0]             err_count
);
  localparam int IW = FW - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GATHER, S_ISSUE, S_WAIT, S_EMIT, S_ERROR
  } state_t;

  state_t                 r_state, w_next;
  logic [MAX_BYTES*8-1:0] r_buf, w_buf_ins, w_buf_first;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [MAX_FIELDS-1:0]  r_null;
  logic [FW-1:0]          r_num, w_num_lat;
  logic [IW-1:0]          r_idx, r_oidx;
  logic [OUT_WIDTH-1:0]   r_value;
  logic                   r_is_null, r_last;
  logic [7:0]             r_err_cnt;
  logic                   w_accept, w_in_ready, w_out_valid;
  logic                   w_dec_act, w_is_last;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_cnt_nxt = (r_state == S_IDLE) ? CW'(1) : r_cnt + CW'(1);
  assign w_is_last = ({1'b0, r_idx} == r_num - FW'(1));

  // Zero and out-of-range counts both mean a full-size template
  assign w_num_lat =
    (tmpl_num_fields == '0 ||
     tmpl_num_fields > FW'(MAX_FIELDS)) ?
    FW'(MAX_FIELDS) : tmpl_num_fields;

  always_comb begin
    w_buf_first      = '0;
    w_buf_first[7:0] = bus.in_byte;
    w_buf_ins        = r_buf;
    for (int i = 0; i < MAX_BYTES; i++)
      if (CW'(i) == r_cnt)
        w_buf_ins[i*8 +: 8] = bus.in_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_GATHER:
        if (w_accept) begin
          if (bus.in_byte[7])
            w_next = S_ISSUE;
          else if (w_cnt_nxt == CW'(MAX_BYTES))
            w_next = S_ERROR;
          else
            w_next = S_GATHER;
        end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:
        w_next = dec_valid_out ? S_EMIT : S_ERROR;
      S_EMIT:
        if (bus.out_ready)
          w_next = r_last ? S_IDLE : S_GATHER;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // in_ready is gated by reset so every output reads 0 while held
  always_comb begin
    w_in_ready   = 1'b0;
    dec_valid_in = 1'b0;
    w_dec_act    = 1'b0;
    w_out_valid  = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      S_IDLE, S_GATHER: w_in_ready = rst_n;
      S_ISSUE: begin
        dec_valid_in = 1'b1;
        w_dec_act    = 1'b1;
      end
      S_WAIT:  w_dec_act   = 1'b1;
      S_EMIT:  w_out_valid = 1'b1;
      S_ERROR: err         = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_cnt     <= '0;
      r_null    <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_oidx    <= '0;
      r_value   <= '0;
      r_is_null <= 1'b0;
      r_last    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_null <= tmpl_nullable;
            r_num  <= w_num_lat;
            r_idx  <= '0;
            r_buf  <= w_buf_first;
            r_cnt  <= CW'(1);
          end
        S_GATHER:
          if (w_accept) begin
            r_buf <= w_buf_ins;
            r_cnt <= w_cnt_nxt;
          end
        S_WAIT:
          if (dec_valid_out) begin
            r_value   <= dec_value;
            r_is_null <= dec_is_null;
            r_oidx    <= r_idx;
            r_last    <= w_is_last;
          end
        S_EMIT:
          if (bus.out_ready) begin
            r_buf <= '0;
            r_cnt <= '0;
            if (!r_last) r_idx <= r_idx + IW'(1);
          end
        S_ERROR: begin
          r_buf <= '0;
          r_cnt <= '0;
          r_idx <= '0;
          if (r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_value     = r_value;
  assign bus.out_is_null   = r_is_null;
  assign bus.out_field_idx = r_oidx;
  assign bus.out_last      = r_last;
  assign dec_msg_bytes     = r_buf;
  assign dec_byte_count    = r_cnt;
  assign dec_nullable      = w_dec_act & r_null[r_idx];
  assign err_count         = r_err_cnt;
endmodule

// File: doc/fast_field_sequencer.md
Name: fast_field_sequencer

Overview:
- Sequences a stream of FAST-encoded bytes through one shared fast_uint_decoder instance.
- Splits the byte stream into fields using stop bits, and buffers each field's bytes.
- Issues each buffered field to the decoder with that field's template nullable flag, then returns the decoded values in order on a valid/ready output.
- Sits between the packet byte unpacker and the message/field assembler.

Parameters:
- MAX_BYTES, 10: maximum bytes per field; must match the decoder's MAX_BYTES.
- OUT_WIDTH, 64: decoded value width; must match the decoder's OUT_WIDTH.
- MAX_FIELDS, 16: maximum number of uint fields per message template.
- CW, $clog2(MAX_BYTES)+1: byte-count width (derived).
- FW, $clog2(MAX_FIELDS)+1: field-count width (derived).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_byte  in  8  FAST byte; bit7 is the stop bit.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- tmpl_nullable  in  MAX_FIELDS  per-field nullable flags; bit i applies to field i.
- tmpl_num_fields  in  FW  number of fields in the message.
- dec_msg_bytes  out  MAX_BYTES*8  field bytes to the decoder; byte i at bits [8i+7:8i]; unused bytes are 0.
- dec_byte_count  out  CW  number of valid bytes in the field.
- dec_nullable  out  1  nullable flag for the current field.
- dec_valid_in  out  1  one-cycle issue strobe to the decoder.
- dec_valid_out  in  1  decoder result valid.
- dec_value  in  OUT_WIDTH  decoder result value.
- dec_is_null  in  1  decoder null flag.
- out_valid  out  1  decoded field available.
- out_ready  in  1  downstream accepts the field.
- out_value  out  OUT_WIDTH  captured decoder value.
- out_is_null  out  1  captured decoder null flag.
- out_field_idx  out  FW-1  field index within the message.
- out_last  out  1  this is the last field of the message.
- err  out  1  one-cycle pulse on a protocol error.
- err_count  out  8  saturating error counter.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0: in_ready, dec_*, out_*, err, err_count.
  - Byte buffer, byte count and field index are 0.
- Reset mid-operation: everything is abandoned immediately; no output pulse is generated.
- States: IDLE, GATHER, ISSUE, WAIT, EMIT, ERROR.
- in_ready is combinational: high only in IDLE and GATHER.
- IDLE, on byte accept:
  - Latch tmpl_nullable and tmpl_num_fields.
  - A tmpl_num_fields value of 0 or greater than MAX_FIELDS is latched as MAX_FIELDS.
  - Set field_idx=0, clear the buffer, and store the byte as buf[0] with cnt=1.
  - Then apply the GATHER stop-bit rules.
- GATHER, on byte accept:
  - Store the byte as buf[cnt] and increment cnt.
  - If bit7=1, go to ISSUE.
  - Else if the new cnt equals MAX_BYTES, go to ERROR.
  - Else stay in GATHER.
- ISSUE (exactly 1 cycle):
  - dec_valid_in=1.
  - dec_msg_bytes=buf, dec_byte_count=cnt, dec_nullable=latched_nullable[field_idx].
  - These dec_* outputs stay stable through WAIT.
  - Go to WAIT.
- WAIT (decoder latency is fixed at 1 cycle):
  - If dec_valid_out=1: capture dec_value, dec_is_null, field_idx, and (field_idx==num_fields-1) into the out_* registers, then go to EMIT.
  - If dec_valid_out=0: go to ERROR.
- EMIT:
  - out_valid=1; out_* hold stable while out_ready=0.
  - On out_valid && out_ready, out_valid drops the next cycle.
  - If this was the last field: go to IDLE.
  - Otherwise: increment field_idx, clear the buffer and cnt, and go to GATHER.
- ERROR (1 cycle):
  - err=1; err_count increments and saturates at 255.
  - Field index, buffer and count are cleared; go to IDLE. The rest of the message is dropped by upstream framing.
- Latency: stop byte accepted at edge N → dec_valid_in high during cycle N+1 → out_valid high from cycle N+3.
- Throughput: the minimum field period is (bytes + 3) cycles; no overlap between fields.
- A single-byte field with its stop bit set goes straight from IDLE/GATHER to ISSUE.
- An error always aborts the whole message; the next accepted byte starts a new message at field 0.
- No output is produced for the field in error.

Test Plan:
- Non-nullable single field: num_fields=1, byte 0x85 → dec_byte_count=1; out_value=5, is_null=0, field_idx=0, last=1; out_valid at N+3.
- Two-byte field: nullable=1, bytes 0x01, 0x80 → raw value 128; out_value=127, is_null=0.
- Null handling: nullable=1, byte 0x80 → out_is_null=1.
- Multi-field sequence with backpressure: num_fields=3, no fields nullable (tmpl_nullable=0), bytes 0x81, 0x7F 0xFF, 0x82; out_ready held low 4 cycles per field.
  - Values 1, 16383, 2 with idx 0, 1, 2; last only on idx 2.
  - in_ready=0 while EMIT waits; outputs stay stable while held.
- Overlong field: 10 bytes 0x01 with no stop bit → err pulse 1 cycle after the 10th accept; err_count=1; no out_valid.
  - Next byte 0x83 with num_fields=1 → out_value=3, field_idx=0.
- Decoder fault and reset: force dec_valid_out=0 in WAIT → err, return to IDLE.
  - Assert rst_n=0 during GATHER → all outputs are 0 and a fresh message decodes correctly afterwards.
